seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner.sv | 132 +++++++++++++
 tb/tb_seven_segment_scanner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed BCD seven-segment scanner with shadow-register updates committed at frame boundaries.
// Optional build macro: LEADING_ZERO_SUPPRESS_EN blanks leading zero digits (digit 0 always shown).
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              segments_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start,
  output logic                    update_pending
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] f_blank_mask(input logic [4*NUM_DIGITS-1:0] val);
    logic [NUM_DIGITS-1:0] mask;
    mask = '0;
`ifdef LEADING_ZERO_SUPPRESS_EN
    begin
      logic all_zero;
      all_zero = 1'b1;
      // Walk down from the top digit; a digit is blank while it and everything above is zero.
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        all_zero = all_zero && (val[4*i +: 4] == 4'h0);
        mask[i]  = all_zero;
      end
    end
`else
    mask = '0;
`endif
    return mask;
  endfunction

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;
  logic                    r_frame_start;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_sel;

  logic                    w_tick;
  logic                    w_wrap;
  logic [IW-1:0]           w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_active_nxt;
  logic [NUM_DIGITS-1:0]   w_mask;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_sel_nxt;

  // Next index and next active value; outputs are built from these so they change with the index.
  always_comb begin
    w_tick    = (r_cnt == CNT_MAX);
    w_wrap    = w_tick && (r_idx == IDX_MAX);
    w_idx_nxt = r_idx;
    if (w_tick) begin
      w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
    end
    w_active_nxt = r_active;
    if (w_wrap && load) begin
      w_active_nxt = bcd_in;
    end else if (w_wrap && r_pending) begin
      w_active_nxt = r_shadow;
    end
    w_mask    = f_blank_mask(w_active_nxt);
    w_nib     = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_seg_nxt = w_mask[w_idx_nxt] ? 7'b0000000 : f_decode(w_nib);
    w_sel_nxt = NUM_DIGITS'(1) << w_idx_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_active      <= '1;
      r_shadow      <= '1;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
      r_seg         <= {7{ACTIVE_LOW}};
      r_sel         <= NUM_DIGITS'(1) ^ {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      r_cnt    <= w_tick ? '0 : r_cnt + CW'(1);
      r_idx    <= w_idx_nxt;
      r_active <= w_active_nxt;
      if (load) begin
        r_shadow <= bcd_in;
      end
      // A load on the wrap edge bypasses the shadow, so nothing is left pending.
      if (load) begin
        r_pending <= !w_wrap;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
      r_frame_start <= w_wrap;
      r_seg         <= w_seg_nxt ^ {7{ACTIVE_LOW}};
      r_sel         <= w_sel_nxt ^ {NUM_DIGITS{ACTIVE_LOW}};
    end
  end

  assign segments_out   = r_seg;
  assign digit_sel      = r_sel;
  assign frame_start    = r_frame_start;
  assign update_pending = r_pending;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: a cycle-arithmetic reference model queues expected outputs, a negedge monitor checks
// an ACTIVE_LOW=0 and an ACTIVE_LOW=1 instance driven by identical stimulus.
module tb_seven_segment_scanner;
  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FR = ND * SD;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic [6:0]  seg_p, seg_n;
  logic [3:0]  sel_p, sel_n;
  logic        fs_p, fs_n, pend_p, pend_n;

  seven_segment_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .segments_out(seg_p), .digit_sel(sel_p), .frame_start(fs_p), .update_pending(pend_p));

  seven_segment_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
    .segments_out(seg_n), .digit_sel(sel_n), .frame_start(fs_n), .update_pending(pend_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [12:0] exp_q[$];

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  // Reference state: edges since reset, displayed value, shadow value.
  int          model_k = 0;
  logic [15:0] m_disp = 16'hFFFF;
  logic [15:0] m_shadow = 16'hFFFF;
  logic        m_pend = 1'b0;

  function automatic logic [6:0] ref_seg(input logic [15:0] val, input int idx);
    logic [15:0] upper;
    int nib;
    upper = val >> (4 * idx);
    nib   = int'(upper & 16'h000F);
`ifdef LEADING_ZERO_SUPPRESS_EN
    if (idx > 0 && upper == 16'h0000) return 7'b0000000;
`endif
    if (nib < 10) return seg_tab[nib];
    return 7'b0000000;
  endfunction

  always @(posedge clk) begin
    logic wrap;
    int idx;
    if (rst) begin
      model_k = 0;
      m_disp  = 16'hFFFF;
      m_shadow = 16'hFFFF;
      m_pend  = 1'b0;
      exp_q.push_back({7'b0000000, 4'b0001, 1'b0, 1'b0});
    end else begin
      model_k = model_k + 1;
      wrap = (model_k % FR == 0);
      if (wrap) begin
        if (load) m_disp = bcd_in;
        else if (m_pend) m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (load) begin
        m_shadow = bcd_in;
        m_pend = 1'b1;
      end
      idx = (model_k / SD) % ND;
      exp_q.push_back({ref_seg(m_disp, idx), 4'(1 << idx), wrap, m_pend});
    end
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({seg_p, sel_p, fs_p, pend_p} !== e ||
          {seg_n, sel_n, fs_n, pend_n} !== {~e[12:2], e[1:0]}) begin
        miscompares++;
        $display("FAIL outputs t=%0t k=%0d seg/sel/fs/pend got %b %b %b %b (inv %b %b %b %b) expected %b %b %b %b",
                 $time, model_k, seg_p, sel_p, fs_p, pend_p, seg_n, sel_n, fs_n, pend_n,
                 e[12:6], e[5:2], e[1], e[0]);
      end
    end
  end

  task automatic tick(input logic l, input logic [15:0] v);
    load = l;
    bcd_in = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 2 * FR && (model_k % FR) != p; i++) tick(1'b0, 16'h0000);
    vectors++;
    if ((model_k % FR) != p) begin
      miscompares++;
      $display("FAIL wait_phase got %0d expected %0d", model_k % FR, p);
    end
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    int z;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    z = $urandom_range(0, ND);
    for (int i = ND - z; i < ND; i++) v[4*i +: 4] = 4'h0;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    load = 1'b0;
    bcd_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    tick(1'b1, 16'hBEEF);
    rst = 1'b0;
    tick(1'b0, 16'h0000);
    tick(1'b1, 16'h1234);
    repeat (40) tick(1'b0, 16'h0000);
    wait_phase(3);
    tick(1'b1, 16'h5678);
    wait_phase(9);
    tick(1'b1, 16'h9999);
    repeat (30) tick(1'b0, 16'h0000);
    wait_phase(15);
    tick(1'b1, 16'h4321);
    repeat (20) tick(1'b0, 16'h0000);
    tick(1'b1, 16'h00A7);
    repeat (40) tick(1'b0, 16'h0000);
    tick(1'b1, 16'h0000);
    repeat (20) tick(1'b0, 16'h0000);
    wait_phase(2);
    tick(1'b1, 16'h1111);
    wait_phase(9);
    rst = 1'b1;
    tick(1'b1, 16'h2222);
    rst = 1'b0;
    repeat (20) tick(1'b0, 16'h0000);
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      tick($urandom_range(0, 9) == 0, rand_bcd());
    end
    rst = 1'b0;
    repeat (FR + 2) tick(1'b0, 16'h0000);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() > 1) begin
      miscompares++;
      $display("FAIL drain got %0d queued expected at most 1", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
